// File: rtl/alu_arbiter.sv
// Round-robin front end that lets two requesters share one external ALU:
// grant, hold operands for the ALU, capture its result, hand it back.
package alu_arbiter_pkg;
  typedef enum logic [3:0] {
    kADD  = 4'h0,
    kADDI = 4'h1,
    kSUB  = 4'h2,
    kAND  = 4'h3,
    kOR   = 4'h4,
    kXOR  = 4'h5,
    kPUSH = 4'h6,
    kBEQ  = 4'h7,
    kBNE  = 4'h8
  } alu_op_e;
endpackage

module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [3:0]   req0_op,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic [1:0]   req0_imm,
  input  logic         req0_ci,
  input  logic         req0_acc_we,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [3:0]   req1_op,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic [1:0]   req1_imm,
  input  logic         req1_ci,
  input  logic         req1_acc_we,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_rslt,
  output logic         rsp_co,
  output logic         rsp_z,
  output logic [3:0]   alu_op,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [W-1:0] alu_acc,
  output logic [1:0]   alu_imm,
  output logic         alu_ci,
  input  logic [W-1:0] alu_rslt,
  input  logic         alu_co,
  input  logic         alu_z,
  output logic [15:0]  op_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_e;

  typedef struct packed {
    alu_op_e      op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   imm;
    logic         ci;
    logic         we;
    logic         id;
  } cmd_t;

  typedef struct packed {
    logic [W-1:0] rslt;
    logic         co;
    logic         z;
  } rsp_t;

  state_e       state_q, state_d;
  cmd_t         cmd_q, cmd_d;
  rsp_t         rsp_q, rsp_d;
  logic [W-1:0] acc_q, acc_d;
  logic [15:0]  op_cnt_q, op_cnt_d;
  logic         last_q, last_d;
  logic         grant_vld;
  logic         grant_id;

  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
    state_d    = state_q;
    cmd_d      = cmd_q;
    rsp_d      = rsp_q;
    acc_d      = acc_q;
    op_cnt_d   = op_cnt_q;
    last_d     = last_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    grant_vld  = req0_valid | req1_valid;
    // On a tie the requester that did not win last time goes first.
    grant_id   = (req0_valid && req1_valid) ? ~last_q : ~req0_valid;

    unique case (state_q)
      S_IDLE: begin
        // ready is gated by rst_n so no grant is offered while reset is held.
        if (grant_vld && rst_n) begin
          req0_ready = ~grant_id;
          req1_ready = grant_id;
          last_d     = grant_id;
          cmd_d.op   = alu_op_e'(grant_id ? req1_op : req0_op);
          cmd_d.a    = grant_id ? req1_a      : req0_a;
          cmd_d.b    = grant_id ? req1_b      : req0_b;
          cmd_d.imm  = grant_id ? req1_imm    : req0_imm;
          cmd_d.ci   = grant_id ? req1_ci     : req0_ci;
          cmd_d.we   = grant_id ? req1_acc_we : req0_acc_we;
          cmd_d.id   = grant_id;
          state_d    = S_EXEC;
        end
      end
      S_EXEC: begin
        rsp_d.rslt = alu_rslt;
        rsp_d.co   = alu_co;
        rsp_d.z    = alu_z;
        if (cmd_q.we) acc_d = alu_rslt;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          op_cnt_d = op_cnt_q + 16'd1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: payload registers are reset too, because they drive the alu_* outputs directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cmd_q    <= '0;
      rsp_q    <= '0;
      acc_q    <= '0;
      op_cnt_q <= '0;
      last_q   <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      rsp_q    <= rsp_d;
      acc_q    <= acc_d;
      op_cnt_q <= op_cnt_d;
      last_q   <= last_d;
    end
  end

  assign rsp_valid = (state_q == S_RESP);
  assign rsp_id    = cmd_q.id;
  assign rsp_rslt  = rsp_q.rslt;
  assign rsp_co    = rsp_q.co;
  assign rsp_z     = rsp_q.z;
  assign alu_op    = cmd_q.op;
  assign alu_a     = cmd_q.a;
  assign alu_b     = cmd_q.b;
  assign alu_imm   = cmd_q.imm;
  assign alu_ci    = cmd_q.ci;
  assign alu_acc   = acc_q;
  assign op_cnt    = op_cnt_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a stub ALU, a transaction-level reference model
// compared against the DUT every cycle, and directed scenarios with literal expectations.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int W  = 8;
  localparam int W1 = W + 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [3:0]   req0_op = '0, req1_op = '0;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [1:0]   req0_imm = '0, req1_imm = '0;
  logic         req0_ci = 1'b0, req1_ci = 1'b0;
  logic         req0_acc_we = 1'b0, req1_acc_we = 1'b0;
  logic         rsp_valid, rsp_id, rsp_co, rsp_z;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] rsp_rslt;
  logic [3:0]   alu_op;
  logic [W-1:0] alu_a, alu_b, alu_acc, alu_rslt;
  logic [1:0]   alu_imm;
  logic         alu_ci, alu_co, alu_z;
  logic [15:0]  op_cnt;

  int checks   = 0;
  int failures = 0;
  int grants[$];

  alu_arbiter #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b), .req0_imm(req0_imm), .req0_ci(req0_ci),
    .req0_acc_we(req0_acc_we),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_imm(req1_imm), .req1_ci(req1_ci),
    .req1_acc_we(req1_acc_we),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_rslt(rsp_rslt), .rsp_co(rsp_co), .rsp_z(rsp_z),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_acc(alu_acc),
    .alu_imm(alu_imm), .alu_ci(alu_ci),
    .alu_rslt(alu_rslt), .alu_co(alu_co), .alu_z(alu_z),
    .op_cnt(op_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] r;
    logic         co;
    logic         z;
  } alu_out_t;

  typedef struct packed {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   imm;
    logic         ci;
    logic         we;
    logic         id;
  } txn_t;

  typedef struct {
    logic [W-1:0] rslt;
    logic         co;
    logic         z;
    logic         id;
  } rsp_t;

  // Behaviour of the external ALU this block drives.
  function automatic alu_out_t alu_f(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic [W-1:0] acc, input logic [1:0] imm, input logic ci);
    alu_out_t     o;
    logic [W:0]   s;
    logic [W-1:0] simm;
    simm = {{(W-2){imm[1]}}, imm};
    s    = '0;
    o    = '0;
    case (op)
      kADD:  s = {1'b0, a} + {1'b0, b} + W1'(ci);
      kADDI: s = {1'b0, a} + {1'b0, b} + W1'(ci) + {1'b0, simm};
      kSUB:  s = {1'b0, a} - {1'b0, b};
      kAND:  s = {1'b0, a & b};
      kOR:   s = {1'b0, a | b};
      kXOR:  s = {1'b0, a ^ b};
      kPUSH: s = {1'b0, b};
      kBEQ:  s = {1'b0, acc} - {1'b0, a};
      kBNE:  s = {1'b0, acc} - {1'b0, a};
      default: s = '0;
    endcase
    o.r  = s[W-1:0];
    o.co = s[W];
    o.z  = (o.r == '0);
    if (op == kBEQ) o.z = (acc == a);
    if (op == kBNE) o.z = (acc != a);
    return o;
  endfunction

  alu_out_t alu_o;
  always_comb alu_o = alu_f(alu_op, alu_a, alu_b, alu_acc, alu_imm, alu_ci);
  assign alu_rslt = alu_o.r;
  assign alu_co   = alu_o.co;
  assign alu_z    = alu_o.z;

  // Reference model: m_age is -1 when free, 0 the cycle after a grant,
  // and >=1 while a response is being offered.
  txn_t         m_txn;
  int           m_age;
  logic         m_last;
  logic [W-1:0] m_acc, m_rslt;
  logic         m_co, m_z;
  int           m_cnt;

  task automatic model_reset();
    m_txn  = '0;
    m_age  = -1;
    m_last = 1'b1;
    m_acc  = '0;
    m_rslt = '0;
    m_co   = 1'b0;
    m_z    = 1'b0;
    m_cnt  = 0;
  endtask

  function automatic int exp_grant();
    if (req0_valid && req1_valid) return m_last ? 0 : 1;
    return req0_valid ? 0 : 1;
  endfunction

  task automatic model_step();
    int       g;
    alu_out_t o;
    if (m_age < 0) begin
      if (req0_valid || req1_valid) begin
        g      = exp_grant();
        m_last = (g == 1);
        if (g == 0) begin
          m_txn.op = req0_op; m_txn.a = req0_a; m_txn.b = req0_b;
          m_txn.imm = req0_imm; m_txn.ci = req0_ci; m_txn.we = req0_acc_we; m_txn.id = 1'b0;
        end else begin
          m_txn.op = req1_op; m_txn.a = req1_a; m_txn.b = req1_b;
          m_txn.imm = req1_imm; m_txn.ci = req1_ci; m_txn.we = req1_acc_we; m_txn.id = 1'b1;
        end
        m_age = 0;
      end
    end else if (m_age == 0) begin
      o      = alu_f(m_txn.op, m_txn.a, m_txn.b, m_acc, m_txn.imm, m_txn.ci);
      m_rslt = o.r;
      m_co   = o.co;
      m_z    = o.z;
      if (m_txn.we) m_acc = o.r;
      m_age = 1;
    end else if (rsp_ready) begin
      m_cnt = (m_cnt + 1) % 65536;
      m_age = -1;
    end else begin
      m_age = m_age + 1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) model_step();
    end
  end

  initial begin
    int   g;
    logic offer;
    forever begin
      @(negedge clk);
      if (req0_ready) grants.push_back(0);
      if (req1_ready) grants.push_back(1);
      g     = exp_grant();
      offer = rst_n && (m_age < 0) && (req0_valid || req1_valid);
      check("req0_ready", 32'(req0_ready), 32'(offer && g == 0));
      check("req1_ready", 32'(req1_ready), 32'(offer && g == 1));
      check("rsp_valid",  32'(rsp_valid),  32'(m_age >= 1));
      check("rsp_id",     32'(rsp_id),     32'(m_txn.id));
      check("rsp_rslt",   32'(rsp_rslt),   32'(m_rslt));
      check("rsp_co",     32'(rsp_co),     32'(m_co));
      check("rsp_z",      32'(rsp_z),      32'(m_z));
      check("alu_op",     32'(alu_op),     32'(m_txn.op));
      check("alu_a",      32'(alu_a),      32'(m_txn.a));
      check("alu_b",      32'(alu_b),      32'(m_txn.b));
      check("alu_imm",    32'(alu_imm),    32'(m_txn.imm));
      check("alu_ci",     32'(alu_ci),     32'(m_txn.ci));
      check("alu_acc",    32'(alu_acc),    32'(m_acc));
      check("op_cnt",     32'(op_cnt),     32'(m_cnt));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rslt",  32'(rsp_rslt),  32'd0);
    check("rst_op_cnt",    32'(op_cnt),    32'd0);
    check("rst_alu_acc",   32'(alu_acc),   32'd0);
    check("rst_req0_ready", 32'(req0_ready), 32'd0);
    check("rst_req1_ready", 32'(req1_ready), 32'd0);
    step();
    rst_n = 1'b1;
  endtask

  task automatic issue(input int n, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [1:0] imm, input logic ci, input logic we);
    if (n == 0) begin
      req0_op = op; req0_a = a; req0_b = b; req0_imm = imm; req0_ci = ci; req0_acc_we = we;
      req0_valid = 1'b1;
    end else begin
      req1_op = op; req1_a = a; req1_b = b; req1_imm = imm; req1_ci = ci; req1_acc_we = we;
      req1_valid = 1'b1;
    end
  endtask

  task automatic wait_grant(input int n);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = (n == 0) ? req0_ready : req1_ready;
    end
    if (!seen) check("grant_timeout", 32'd0, 32'd1);
    step();
    if (n == 0) req0_valid = 1'b0;
    else        req1_valid = 1'b0;
  endtask

  task automatic wait_rsp(output rsp_t r);
    logic seen;
    seen = 1'b0;
    r    = '{default: '0};
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = rsp_valid;
    end
    if (!seen) check("rsp_timeout", 32'd0, 32'd1);
    r.rslt = rsp_rslt;
    r.co   = rsp_co;
    r.z    = rsp_z;
    r.id   = rsp_id;
    step();
  endtask

  task automatic run(input int n, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [1:0] imm, input logic ci, input logic we, output rsp_t r);
    issue(n, op, a, b, imm, ci, we);
    wait_grant(n);
    wait_rsp(r);
  endtask

  initial begin
    rsp_t r;
    int   exp_g[4];
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    rsp_t r;
    int   exp_g[4];
    exp_g = '{0, 1, 0, 1};
    model_reset();

    // Single op with literal latency and result.
    do_reset();
    rsp_ready = 1'b1;
    issue(0, kADDI, 8'h05, 8'h03, 2'b00, 1'b1, 1'b0);
    wait_grant(0);
    @(negedge clk);
    check("single_exec_no_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check("single_rsp_valid", 32'(rsp_valid), 32'd1);
    check("single_rsp_id",    32'(rsp_id),    32'd0);
    check("single_rsp_rslt",  32'(rsp_rslt),  32'h09);
    step();
    @(negedge clk);
    check("single_op_cnt", 32'(op_cnt), 32'd1);
    check("single_idle",   32'(rsp_valid), 32'd0);
    step();

    // Tie: both requesters valid straight out of reset.
    grants.delete();
    issue(0, kADD, 8'h01, 8'h02, 2'b00, 1'b0, 1'b0);
    issue(1, kXOR, 8'hF0, 8'h0F, 2'b00, 1'b0, 1'b0);
    do_reset();
    repeat (12) @(negedge clk);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (4) step();
    check("tie_grant_count_ge4", 32'(grants.size() >= 4), 32'd1);
    if (grants.size() >= 4)
      for (int i = 0; i < 4; i++) check("tie_grant_order", 32'(grants[i]), 32'(exp_g[i]));
    for (int i = 1; i < grants.size(); i++)
      check("tie_no_repeat", 32'(grants[i] != grants[i-1]), 32'd1);

    // Backpressure while the other requester waits.
    rsp_ready = 1'b0;
    run(0, kSUB, 8'h10, 8'h20, 2'b00, 1'b0, 1'b0, r);
    check("bp_rslt_value", 32'(r.rslt), 32'hF0);
    issue(1, kOR, 8'h30, 8'h03, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid_held", 32'(rsp_valid),  32'd1);
      check("bp_rslt_held",  32'(rsp_rslt),   32'(r.rslt));
      check("bp_ready0",     32'(req0_ready), 32'd0);
      check("bp_ready1",     32'(req1_ready), 32'd0);
    end
    step();
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_last_valid", 32'(rsp_valid), 32'd1);
    @(negedge clk);
    check("bp_released_idle", 32'(rsp_valid),  32'd0);
    check("bp_next_grant",    32'(req1_ready), 32'd1);
    step();
    req1_valid = 1'b0;
    wait_rsp(r);
    check("bp_or_rslt", 32'(r.rslt), 32'h33);

    // Accumulator path through PUSH / BEQ / BNE.
    run(1, kPUSH, 8'h00, 8'h00, 2'b00, 1'b0, 1'b1, r);
    issue(0, kBEQ, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0);
    wait_grant(0);
    check("acc_zero", 32'(alu_acc), 32'h00);
    wait_rsp(r);
    check("beq_eq_z", 32'(r.z), 32'd1);
    run(1, kPUSH, 8'h00, 8'h07, 2'b00, 1'b0, 1'b1, r);
    check("acc_seven", 32'(alu_acc), 32'h07);
    run(0, kBNE, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, r);
    check("bne_ne_z", 32'(r.z), 32'd1);
    run(0, kBEQ, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, r);
    check("beq_ne_z", 32'(r.z), 32'd0);

    // Reset during EXEC of an accumulator-writing op.
    issue(0, kPUSH, 8'h00, 8'h55, 2'b00, 1'b0, 1'b1);
    wait_grant(0);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("midrst_valid",  32'(rsp_valid), 32'd0);
    check("midrst_acc",    32'(alu_acc),   32'd0);
    check("midrst_op_cnt", 32'(op_cnt),    32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("midrst_no_rsp", 32'(rsp_valid), 32'd0);
      check("midrst_acc_kept", 32'(alu_acc), 32'd0);
    end
    step();

    // Counter wrap from a preloaded 0xFFFF.
    force dut.op_cnt_q = 16'hFFFF;
    m_cnt = 65535;
    #1;
    release dut.op_cnt_q;
    @(negedge clk);
    check("wrap_preload", 32'(op_cnt), 32'hFFFF);
    step();
    run(0, kAND, 8'h3C, 8'h0F, 2'b00, 1'b0, 1'b0, r);
    check("wrap_and_rslt", 32'(r.rslt), 32'h0C);
    @(negedge clk);
    check("wrap_op_cnt", 32'(op_cnt), 32'h0000);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
